gbe64_frame_packer: RTL and testbench
=====================================

Name: gbe64_frame_packer

Overview:
- Sits downstream of the software-written words-per-frame register. Consumes its 32-bit `words_per_frame` value and a 64-bit photon word stream.
- Buffers incoming words in an internal FIFO and emits fixed-length frames to the 10GbE core TX interface, asserting end-of-frame on the last word.
- A partial frame is flushed after an idle timeout so that low-rate data still leaves the board.

Parameters:
- FIFO_DEPTH, 2048, words of 64-bit buffering (power of 2).
- MAX_WORDS, 1024, upper clamp on frame length in words (8 KiB jumbo payload).
- TIMEOUT_CYCLES, 65536, consecutive idle-input cycles before a partial frame is flushed.

Ports:
- user_clk  in  1  sole clock, shared with the 10GbE TX domain.
- user_rst_n  in  1  asynchronous active-low reset.
- words_per_frame  in  32  frame length from the software register. Quasi-static; sampled only at frame start.
- in_data  in  64  photon word.
- in_valid  in  1  in_data valid this cycle. No backpressure to the source.
- tx_data  out  64  word to the 10GbE core.
- tx_valid  out  1  tx_data valid.
- tx_end_of_frame  out  1  last word of the frame; only high together with tx_valid.
- tx_afull  in  1  10GbE TX almost-full; stall request.
- frame_count  out  32  frames sent, wraps.
- drop_count  out  32  input words dropped on FIFO full, saturates at 0xFFFFFFFF.
- overflow  out  1  sticky; set on the first dropped word, cleared only by reset.
- fill_level  out  12  current FIFO occupancy (log2(FIFO_DEPTH)+1 bits).

Behaviour:
- Reset: user_clk is the sole clock; user_rst_n is asynchronous, active-low. While low, all outputs are 0, the FIFO is empty, the FSM is in IDLE and the idle timer is 0. Reset mid-frame abandons the frame with no end_of_frame; the first frame after reset starts cleanly.
- Frame length: sampled into len_q at each IDLE->SEND transition.
  - len_q = 1 if words_per_frame == 0.
  - len_q = MAX_WORDS if words_per_frame > MAX_WORDS.
  - Otherwise len_q = words_per_frame.
  - Changes to words_per_frame mid-frame have no effect on the current frame.
- Input path: each cycle in_valid=1 writes in_data to the FIFO.
  - If the FIFO is full that cycle, the word is dropped, drop_count increments (saturating) and overflow sets.
  - A simultaneous write and read on a full FIFO still counts as full, so the word is dropped.
- Idle timer:
  - Resets to 0 on any in_valid.
  - Increments otherwise, saturating at TIMEOUT_CYCLES.
  - timeout = (timer == TIMEOUT_CYCLES) and fill_level > 0.
- FSM IDLE:
  - Go to SEND when tx_afull=0 and either (fill_level >= len_q_candidate) or timeout.
  - len_q is latched on this transition. On a timeout start, burst = min(fill_level, len_q); otherwise burst = len_q.
  - The idle timer clears on entry to SEND.
- FSM SEND:
  - Each cycle with tx_afull=0, pop one word and drive tx_valid=1, tx_data=word. A word counter runs 1..burst.
  - On the word where counter == burst: tx_end_of_frame=1, frame_count increments, next state IDLE.
  - While tx_afull=1: tx_valid=0, no pop, counter holds; resume when it deasserts.
  - The FIFO never underruns in SEND, because burst <= fill_level at start.
- Latency:
  - tx outputs are registered.
  - The first tx_valid is 1 cycle after the IDLE->SEND decision.
  - The minimum gap between frames is 1 idle cycle (IDLE re-evaluation).
- fill_level reflects writes and reads of the previous cycle, i.e. it is registered.

Test Plan:
- words_per_frame=4, 12 consecutive in_valid words 0..11, tx_afull=0 -> three frames [0-3], [4-7], [8-11]; tx_end_of_frame on words 3, 7, 11; frame_count=3; drop_count=0.
- words_per_frame=0, then 5000 -> 3 words produce three 1-word frames. After changing to 5000, frames are 1024 words (MAX_WORDS clamp).
- words_per_frame=100, 10 words then silence, TIMEOUT_CYCLES=16 in test -> one 10-word frame starts ~17 cycles after the last input, end_of_frame on word 9; no further frames.
- words_per_frame=8, tx_afull pulsed high for 5 cycles mid-frame -> tx_valid low for exactly those cycles; all 8 words in order, no duplicates or losses.
- tx_afull held high, 2050 words pushed with FIFO_DEPTH=2048 -> fill_level=2048, drop_count=2, overflow=1. Release tx_afull -> buffered words drain in order; overflow stays 1.
- Assert user_rst_n=0 on word 3 of an 8-word frame -> all outputs 0 immediately. After release, new input forms a fresh complete frame; frame_count restarts from 0.

Source files
------------

// File: rtl/gbe64_frame_packer_if.sv
// Photon word input stream and 10GbE TX bus of the frame packer.
// The packer is the master of the TX side and the sink of the input stream.
interface gbe64_frame_packer_if;
  logic [63:0] in_data;
  logic        in_valid;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_end_of_frame;
  logic        tx_afull;

  // Packer side: consumes photon words and the TX stall, drives the TX word.
  modport master (
    input  in_data,
    input  in_valid,
    input  tx_afull,
    output tx_data,
    output tx_valid,
    output tx_end_of_frame
  );

  // Environment side: photon source plus the 10GbE core.
  modport slave (
    output in_data,
    output in_valid,
    output tx_afull,
    input  tx_data,
    input  tx_valid,
    input  tx_end_of_frame
  );
endinterface

// File: rtl/gbe64_frame_packer.sv
// Buffers 64-bit photon words in a block-RAM FIFO and emits fixed-length
// frames to the 10GbE TX core. Partial frames are flushed once the input
// has been idle for TIMEOUT_CYCLES.
module gbe64_frame_packer #(
  parameter int FIFO_DEPTH     = 2048,
  parameter int MAX_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = $clog2(MAX_WORDS + 1),
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  user_clk,
  input  logic                  user_rst_n,
  input  logic [31:0]           words_per_frame,
  gbe64_frame_packer_if.master  bus,
  output logic [31:0]           frame_count,
  output logic [31:0]           drop_count,
  output logic                  overflow,
  output logic [AW:0]           fill_level
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [LW-1:0]   burst_reg, burst_next;
  logic [LW-1:0]   cnt_reg, cnt_next;
  logic [LW-1:0]   len_cand;
  logic            pop, start, frame_done;
  logic            fill_ge_len;

  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            full, wr_en, timeout;
  logic [TW-1:0]   timer_reg;

  logic [63:0]     mem [FIFO_DEPTH];
  logic [63:0]     rd_word_reg;
  logic            tx_valid_reg, tx_eof_reg;
  logic [31:0]     frame_count_reg, drop_count_reg;
  logic            overflow_reg;

  // Clamp the software frame length into 1..MAX_WORDS.
  always_comb begin
    len_cand = words_per_frame[LW-1:0];
    if (words_per_frame == 32'd0) begin
      len_cand = LW'(1);
    end else if (words_per_frame > 32'(MAX_WORDS)) begin
      len_cand = LW'(MAX_WORDS);
    end
  end

  assign full        = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign wr_en       = bus.in_valid && !full;
  assign timeout     = (timer_reg == TW'(TIMEOUT_CYCLES)) && (count_reg != '0);
  assign fill_ge_len = (32'(count_reg) >= 32'(len_cand));

  // Frame FSM: next state, pop request and burst bookkeeping.
  always_comb begin
    state_next = state_reg;
    burst_next = burst_reg;
    cnt_next   = cnt_reg;
    pop        = 1'b0;
    start      = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!bus.tx_afull && (fill_ge_len || timeout)) begin
          start      = 1'b1;
          state_next = SEND;
          cnt_next   = '0;
          // A timeout start with less than a full frame sends what is buffered.
          burst_next = fill_ge_len ? len_cand : LW'(count_reg);
        end
      end
      SEND: begin
        if (!bus.tx_afull) begin
          pop      = 1'b1;
          cnt_next = cnt_reg + LW'(1);
          if (cnt_reg + LW'(1) == burst_reg) begin
            frame_done = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, frame length and word counter registers.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_reg <= IDLE;
      burst_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      burst_reg <= burst_next;
      cnt_reg   <= cnt_next;
    end
  end

  // FIFO storage with a registered read port so it maps onto block RAM.
  always_ff @(posedge user_clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= bus.in_data;
    end
    if (pop) begin
      rd_word_reg <= mem[rd_ptr_reg];
    end
  end

  // FIFO pointers and occupancy; a full FIFO rejects even when a pop coincides.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end

  // Idle timer: restarts on input or frame start, saturates at the timeout.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      timer_reg <= '0;
    end else if (bus.in_valid || start) begin
      timer_reg <= '0;
    end else if (timer_reg != TW'(TIMEOUT_CYCLES)) begin
      timer_reg <= timer_reg + TW'(1);
    end
  end

  // Registered TX qualifiers and frame counter.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      tx_valid_reg    <= 1'b0;
      tx_eof_reg      <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      tx_valid_reg <= pop;
      tx_eof_reg   <= frame_done;
      if (frame_done) begin
        frame_count_reg <= frame_count_reg + 32'd1;
      end
    end
  end

  // Drop accounting: saturating counter plus sticky overflow flag.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      drop_count_reg <= '0;
      overflow_reg   <= 1'b0;
    end else if (bus.in_valid && full) begin
      overflow_reg <= 1'b1;
      if (drop_count_reg != 32'hFFFF_FFFF) begin
        drop_count_reg <= drop_count_reg + 32'd1;
      end
    end
  end

  // The RAM output register has no reset, so the data is qualified by valid.
  assign bus.tx_data         = tx_valid_reg ? rd_word_reg : 64'd0;
  assign bus.tx_valid        = tx_valid_reg;
  assign bus.tx_end_of_frame = tx_eof_reg;
  assign frame_count         = frame_count_reg;
  assign drop_count          = drop_count_reg;
  assign overflow            = overflow_reg;
  assign fill_level          = count_reg;

endmodule

// File: tb/tb_gbe64_frame_packer.sv
// Scoreboard bench for gbe64_frame_packer. The reference model splits the
// accepted word stream into chunks of the clamped frame length; the leftover
// words of a stream form one final flushed frame.
module tb_gbe64_frame_packer;
  localparam int DEPTH   = 2048;
  localparam int MAXW    = 1024;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [63:0] data;
    logic        eof;
  } exp_t;

  logic        user_clk = 1'b0;
  logic        user_rst_n = 1'b0;
  logic [31:0] wpf = 32'd4;
  logic [31:0] frame_count, drop_count;
  logic        overflow;
  logic [11:0] fill_level;
  logic        afull_dir = 1'b0, afull_rand = 1'b0, rand_en = 1'b0;

  int checks = 0;
  int failures = 0;
  exp_t        sb_q[$];
  logic [63:0] pend_q[$];
  int model_len = 1;
  int exp_frames = 0;
  int exp_drops = 0;
  int mon_words = 0;
  int mon_in_frame = 0;
  int cur_gaps = 0;
  int last_gaps = 0;

  gbe64_frame_packer_if bus ();

  assign bus.tx_afull = afull_dir | (rand_en & afull_rand);

  gbe64_frame_packer #(
    .FIFO_DEPTH(DEPTH),
    .MAX_WORDS(MAXW),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .user_clk(user_clk),
    .user_rst_n(user_rst_n),
    .words_per_frame(wpf),
    .bus(bus),
    .frame_count(frame_count),
    .drop_count(drop_count),
    .overflow(overflow),
    .fill_level(fill_level)
  );

  always #5 user_clk = ~user_clk;

  // Random TX stall source, only active while rand_en is set.
  always @(negedge user_clk) afull_rand <= ($urandom_range(0, 3) == 0);

  // Monitor: compare every presented word against the scoreboard.
  always @(negedge user_clk) begin
    if (!user_rst_n) begin
      mon_in_frame = 0;
      cur_gaps = 0;
    end else if (bus.tx_valid) begin
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL tx_unexpected word=%0d actual data=%h eof=%0b required no word", mon_words, bus.tx_data, bus.tx_end_of_frame);
      end else begin
        e = sb_q.pop_front();
        if (bus.tx_data !== e.data || bus.tx_end_of_frame !== e.eof) begin
          failures++;
          $display("FAIL tx_word word=%0d actual data=%h eof=%0b required data=%h eof=%0b", mon_words, bus.tx_data, bus.tx_end_of_frame, e.data, e.eof);
        end
      end
      mon_words++;
      mon_in_frame++;
      if (bus.tx_end_of_frame) begin
        last_gaps = cur_gaps;
        cur_gaps = 0;
        mon_in_frame = 0;
      end
    end else begin
      if (mon_in_frame > 0) cur_gaps++;
      if (bus.tx_end_of_frame) begin
        checks++;
        failures++;
        $display("FAIL eof_without_valid actual eof=1 required eof=0");
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  function automatic int clamp_len(input logic [31:0] w);
    if (w == 32'd0) return 1;
    if (w > 32'(MAXW)) return MAXW;
    return int'(w);
  endfunction

  task automatic set_wpf(input logic [31:0] w);
    wpf = w;
    model_len = clamp_len(w);
  endtask

  task automatic emit_chunk(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = pend_q.pop_front();
      e.eof  = (i == n - 1);
      sb_q.push_back(e);
    end
    exp_frames++;
  endtask

  task automatic send_word(input logic [63:0] d, input bit accept);
    @(negedge user_clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    if (accept) begin
      pend_q.push_back(d);
      if (pend_q.size() == model_len) emit_chunk(model_len);
    end else begin
      exp_drops++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge user_clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic end_stream();
    idle(1);
    if (pend_q.size() > 0) emit_chunk(pend_q.size());
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge user_clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain actual pending=%0d required pending=0", name, sb_q.size());
      sb_q.delete();
    end
    repeat (40) @(negedge user_clk);
  endtask

  task automatic wait_in_frame(input int k, input int budget);
    int n = 0;
    @(negedge user_clk);
    #1;
    while (mon_in_frame != k && n < budget) begin
      @(negedge user_clk);
      #1;
      n++;
    end
    checks++;
    if (mon_in_frame != k) begin
      failures++;
      $display("FAIL wait_in_frame actual=%0d required=%0d", mon_in_frame, k);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bus.in_valid = 1'b0;
    bus.in_data  = 64'd0;
    repeat (3) @(negedge user_clk);
    chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("rst_tx_eof", 64'(bus.tx_end_of_frame), 64'd0);
    chk("rst_tx_data", bus.tx_data, 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    user_rst_n = 1'b1;

    // Three 4-word frames from 12 consecutive words.
    set_wpf(32'd4);
    for (int i = 0; i < 12; i++) send_word(64'(i), 1'b1);
    end_stream();
    wait_drain("len4", 200);
    chk("len4_frame_count", 64'(frame_count), 64'(exp_frames));
    chk("len4_drop_count", 64'(drop_count), 64'd0);
    chk("len4_fill", 64'(fill_level), 64'd0);

    // Zero length clamps to 1, oversize clamps to MAX_WORDS.
    set_wpf(32'd0);
    for (int i = 0; i < 3; i++) send_word(64'(100 + i), 1'b1);
    end_stream();
    wait_drain("len0", 200);
    chk("len0_frame_count", 64'(frame_count), 64'(exp_frames));
    set_wpf(32'd5000);
    for (int i = 0; i < MAXW; i++) send_word({$urandom, $urandom}, 1'b1);
    end_stream();
    wait_drain("clamp", 3000);
    chk("clamp_frame_count", 64'(frame_count), 64'(exp_frames));

    // Partial frame leaves after the idle timeout.
    set_wpf(32'd100);
    for (int i = 0; i < 10; i++) send_word(64'(200 + i), 1'b1);
    end_stream();
    lat = 1;
    while (!bus.tx_valid && lat < 100) begin
      @(negedge user_clk);
      lat++;
    end
    checks++;
    if (lat < TIMEOUT + 1 || lat > TIMEOUT + 4) begin
      failures++;
      $display("FAIL timeout_latency actual=%0d required=%0d..%0d", lat, TIMEOUT + 1, TIMEOUT + 4);
    end
    wait_drain("timeout", 300);
    chk("timeout_frame_count", 64'(frame_count), 64'(exp_frames));

    // Five-cycle stall in the middle of an 8-word frame.
    set_wpf(32'd8);
    for (int i = 0; i < 8; i++) send_word(64'(300 + i), 1'b1);
    end_stream();
    wait_in_frame(3, 100);
    afull_dir = 1'b1;
    repeat (5) @(negedge user_clk);
    afull_dir = 1'b0;
    wait_drain("stall", 200);
    chk("stall_gap_cycles", 64'(last_gaps), 64'd5);

    // Overfill with TX stalled: two words dropped, then drain in order.
    set_wpf(32'd1024);
    afull_dir = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) send_word({32'hABCD_0000, 32'(i)}, i < DEPTH);
    end_stream();
    repeat (3) @(negedge user_clk);
    chk("full_fill", 64'(fill_level), 64'(DEPTH));
    chk("full_drop_count", 64'(drop_count), 64'(exp_drops));
    chk("full_overflow", 64'(overflow), 64'd1);
    afull_dir = 1'b0;
    wait_drain("full", 5000);
    chk("full_overflow_sticky", 64'(overflow), 64'd1);
    chk("full_fill_after", 64'(fill_level), 64'd0);
    chk("full_frame_count", 64'(frame_count), 64'(exp_frames));

    // Randomized lengths, bursts and TX stalls.
    rand_en = 1'b1;
    for (int it = 0; it < 15; it++) begin
      int n;
      set_wpf(32'($urandom_range(0, 24)));
      n = $urandom_range(1, 70);
      for (int i = 0; i < n; i++) begin
        send_word({$urandom, $urandom}, 1'b1);
        idle($urandom_range(0, 4));
      end
      end_stream();
      wait_drain("random", 3000);
      chk("random_frame_count", 64'(frame_count), 64'(exp_frames));
    end
    rand_en = 1'b0;
    chk("random_drop_count", 64'(drop_count), 64'(exp_drops));

    // Reset in the middle of a frame abandons it.
    set_wpf(32'd8);
    for (int i = 0; i < 8; i++) send_word(64'(500 + i), 1'b1);
    end_stream();
    wait_in_frame(3, 100);
    user_rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("midrst_tx_eof", 64'(bus.tx_end_of_frame), 64'd0);
    chk("midrst_tx_data", bus.tx_data, 64'd0);
    chk("midrst_frame_count", 64'(frame_count), 64'd0);
    chk("midrst_drop_count", 64'(drop_count), 64'd0);
    chk("midrst_overflow", 64'(overflow), 64'd0);
    chk("midrst_fill", 64'(fill_level), 64'd0);
    sb_q.delete();
    pend_q.delete();
    exp_frames = 0;
    exp_drops = 0;
    @(negedge user_clk);
    user_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send_word(64'(600 + i), 1'b1);
    end_stream();
    wait_drain("after_rst", 200);
    chk("after_rst_frame_count", 64'(frame_count), 64'(exp_frames));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
